// File: rtl/div_sched_pkg.sv
// Shared types and default sizing for the divider scheduler.
package div_sched_pkg;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/div_sched_if.sv
// Requester-side and divider-side signals of div_sched; master is the scheduler.
interface div_sched_if import div_sched_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] x_in;
  logic [N_REQ*W-1:0] y_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       quotient;
  logic [W-1:0]       remainder;
  logic               err;
  logic               busy;
  logic               div_clear;
  logic               div_start;
  logic [W-1:0]       div_x;
  logic [W-1:0]       div_y;
  logic [W-1:0]       div_quotient;
  logic [W-1:0]       div_remainder;
  logic               div_done;

  modport master (
    input  req, x_in, y_in, div_quotient, div_remainder, div_done,
    output gnt, rsp_valid, quotient, remainder, err, busy,
           div_clear, div_start, div_x, div_y
  );

  modport slave (
    output req, x_in, y_in, div_quotient, div_remainder, div_done,
    input  gnt, rsp_valid, quotient, remainder, err, busy,
           div_clear, div_start, div_x, div_y
  );
endinterface

// File: rtl/div_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit at rr, rr+1, ... mod N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(rr) + i) % N);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider among N_REQ requesters.
// Optional DIV_ZERO_CHECK_EN answers y==0 requests directly without starting the divider.
module div_sched import div_sched_pkg::*; #(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic         clk,
  input logic         reset,
  div_sched_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    rr, win, pick;
  logic             any;
  logic [W-1:0]     x_q, y_q, q_q, r_q;
  logic             err_q;
  logic [CW-1:0]    cnt;
  logic             tmo;
  logic             div_zero;
  logic [N_REQ-1:0] win_oh;

  rr_pick #(.N(N_REQ)) u_pick (
    .req (bus.req),
    .rr  (rr),
    .idx (pick),
    .any (any)
  );

`ifdef DIV_ZERO_CHECK_EN
  assign div_zero = (y_q == '0);
`else
  assign div_zero = 1'b0;
`endif

  // Last permitted WAIT cycle; a done seen in that same cycle still wins.
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = CLEAR;
      CLEAR:   state_nxt = div_zero ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.div_done || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr    <= '0;
      win   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          win <= pick;
          x_q <= bus.x_in[int'(pick)*W +: W];
          y_q <= bus.y_in[int'(pick)*W +: W];
          rr  <= (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
        end
        CLEAR: if (div_zero) begin
          q_q   <= '1;
          r_q   <= x_q;
          err_q <= 1'b1;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.div_done) begin
            q_q   <= bus.div_quotient;
            r_q   <= bus.div_remainder;
            err_q <= 1'b0;
          end else if (tmo) begin
            q_q   <= '0;
            r_q   <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign bus.gnt       = (state == CLEAR) ? win_oh : '0;
  assign bus.rsp_valid = (state == RESP)  ? win_oh : '0;
  assign bus.div_clear = (state == CLEAR);
  assign bus.div_start = (state == ISSUE);
  assign bus.busy      = (state != IDLE);
  assign bus.div_x     = x_q;
  assign bus.div_y     = y_q;
  assign bus.quotient  = q_q;
  assign bus.remainder = r_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: vector table, hand sequences and randomized round-robin traffic.
module tb_div_sched;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  typedef struct {
    int         idx;
    logic [7:0] x, y;
    int         lat;
    bit         hang;
    logic [7:0] eq, er;
    bit         eerr;
    int         ersp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_sched_if #(.N_REQ(N), .W(W)) bus();
  div_sched #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat;
  bit hang;
  int mcnt;
  bit mrun;
  logic [3:0] pend;
  logic [7:0] xs[4], ys[4];
  vec_t tbl[6];

  always @(posedge clk) cyc <= cyc + 1;

  // Divider stand-in: result after lat cycles from start, done sticky until clear.
  always @(posedge clk) begin
    if (reset) begin
      bus.div_done <= 1'b0; bus.div_quotient <= '0; bus.div_remainder <= '0;
      mrun <= 1'b0; mcnt <= 0;
    end else if (bus.div_clear) begin
      bus.div_done <= 1'b0; mrun <= 1'b0;
    end else if (bus.div_start) begin
      if (bus.div_y == 0) begin
        bus.div_quotient <= '1; bus.div_remainder <= bus.div_x;
      end else begin
        bus.div_quotient <= bus.div_x / bus.div_y; bus.div_remainder <= bus.div_x % bus.div_y;
      end
      if (!hang && lat <= 1) bus.div_done <= 1'b1;
      else begin mrun <= 1'b1; mcnt <= lat - 1; end
    end else if (mrun && !hang) begin
      if (mcnt <= 1) begin bus.div_done <= 1'b1; mrun <= 1'b0; end
      else mcnt <= mcnt - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++; n_fail++;
    $display("FAIL %s: event not seen within cycle bound", name);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " gnt"}, bus.gnt, 0);           chk({tag, " rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, " quotient"}, bus.quotient, 0); chk({tag, " remainder"}, bus.remainder, 0);
    chk({tag, " err"}, bus.err, 0);           chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " div_clear"}, bus.div_clear, 0); chk({tag, " div_start"}, bus.div_start, 0);
    chk({tag, " div_x"}, bus.div_x, 0);       chk({tag, " div_y"}, bus.div_y, 0);
  endtask

  // Follows one transaction from its IDLE cycle (cycle 0) to the following IDLE.
  task automatic observe(input int w, input logic [7:0] eq, input logic [7:0] er, input bit eerr,
                         input int ersp, input bit estart, input string tag);
    int t0 = cyc;
    int c, sc = 0;
    bit gg = 0, gr = 0, ss = 0;
    for (int k = 0; k < 60 && !gr; k++) begin
      @(negedge clk);
      c = cyc - t0;
      if (bus.div_start) begin ss = 1; sc = c; end
      if (bus.gnt != '0) begin
        gg = 1;
        chk({tag, " gnt"}, bus.gnt, 64'(1) << w);
        chk({tag, " gnt cycle"}, c, 1);
        bus.req[w] = 1'b0;
      end
      if (bus.rsp_valid != '0) begin
        gr = 1;
        chk({tag, " rsp_valid"}, bus.rsp_valid, 64'(1) << w);
        chk({tag, " rsp cycle"}, c, ersp);
        chk({tag, " quotient"}, bus.quotient, eq);
        chk({tag, " remainder"}, bus.remainder, er);
        chk({tag, " err"}, bus.err, eerr);
      end
    end
    if (!gg) bound_fail({tag, " gnt"});
    if (!gr) bound_fail({tag, " rsp"});
    chk({tag, " start seen"}, ss, estart);
    if (estart) chk({tag, " start cycle"}, sc, 2);
    @(negedge clk);
    chk({tag, " idle after"}, bus.busy, 0);
  endtask

  task automatic run_op(input int idx, input logic [7:0] x, input logic [7:0] y, input int l,
                        input bit h, input logic [7:0] eq, input logic [7:0] er, input bit eerr,
                        input int ersp, input bit estart, input string tag);
    lat = l; hang = h;
    bus.x_in[idx*W +: W] = x;
    bus.y_in[idx*W +: W] = y;
    bus.req[idx] = 1'b1;
    observe(idx, eq, er, eerr, ersp, estart, tag);
  endtask

  // Holds mask until n grants are seen; checks order, turnaround and each response.
  task automatic run_fair(input logic [3:0] mask, input int n, input int order[4], input string tag);
    int ng = 0, nr = 0, last = -1, tprev = 0, g;
    logic [7:0] ex, ey;
    lat = 2; hang = 0;
    for (int i = 0; i < 4; i++) begin
      bus.x_in[i*W +: W] = 8'(30 + 37 * i);
      bus.y_in[i*W +: W] = 8'(i + 2);
    end
    bus.req = mask;
    for (int k = 0; k < 200 && nr < n; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        g = oh2i(bus.gnt);
        if (ng < n) chk($sformatf("%s gnt#%0d", tag, ng), g, order[ng]);
        if (ng > 0) chk($sformatf("%s turnaround#%0d", tag, ng), cyc - tprev, lat + 4);
        tprev = cyc; last = g; ng++;
        if (ng == n) bus.req = '0;
      end
      if (bus.rsp_valid != '0 && last >= 0) begin
        ex = 8'(30 + 37 * last); ey = 8'(last + 2);
        chk($sformatf("%s rsp#%0d", tag, nr), bus.rsp_valid, 64'(1) << last);
        chk($sformatf("%s q#%0d", tag, nr), bus.quotient, ex / ey);
        chk($sformatf("%s r#%0d", tag, nr), bus.remainder, ex % ey);
        chk($sformatf("%s err#%0d", tag, nr), bus.err, 0);
        nr++;
      end
    end
    if (nr < n) bound_fail({tag, " responses"});
    @(negedge clk);
    chk({tag, " idle after"}, bus.busy, 0);
  endtask

  task automatic add_req(input int i);
    pend[i] = 1'b1;
    xs[i] = 8'($urandom_range(255));
    ys[i] = 8'($urandom_range(255, 1));
    bus.x_in[i*W +: W] = xs[i];
    bus.y_in[i*W +: W] = ys[i];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mrr, w, l;
    bit eerr;
    logic [7:0] eq, er;

    tbl[0] = '{0, 8'd100, 8'd7,  3,  1'b0, 8'd14,  8'd2, 1'b0, 6};
    tbl[1] = '{1, 8'd255, 8'd1,  1,  1'b0, 8'd255, 8'd0, 1'b0, 4};
    tbl[2] = '{2, 8'd5,   8'd9,  2,  1'b0, 8'd0,   8'd5, 1'b0, 5};
    tbl[3] = '{3, 8'd200, 8'd13, 16, 1'b0, 8'd15,  8'd5, 1'b0, 19};
    tbl[4] = '{1, 8'd200, 8'd13, 17, 1'b0, 8'd0,   8'd0, 1'b1, 19};
    tbl[5] = '{0, 8'd9,   8'd3,  0,  1'b1, 8'd0,   8'd0, 1'b1, 19};

    reset = 1'b1; bus.req = '0; bus.x_in = '0; bus.y_in = '0; lat = 1; hang = 0; pend = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    run_fair(4'b1111, 4, '{0, 1, 2, 3}, "fair4");
    run_fair(4'b0101, 2, '{0, 2, 0, 0}, "fair02");

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].lat, tbl[i].hang,
             tbl[i].eq, tbl[i].er, tbl[i].eerr, tbl[i].ersp, 1'b1, $sformatf("vec%0d", i));

    // Back-to-back with a slower second op: stale sticky done must not answer it.
    run_op(1, 8'd60, 8'd4,  2, 1'b0, 8'd15, 8'd0, 1'b0, 5, 1'b1, "sticky_a");
    run_op(2, 8'd99, 8'd10, 5, 1'b0, 8'd9,  8'd9, 1'b0, 8, 1'b1, "sticky_b");

`ifdef DIV_ZERO_CHECK_EN
    run_op(2, 8'd55, 8'd0, 3, 1'b0, 8'hFF, 8'd55, 1'b1, 2, 1'b0, "divzero");
`else
    run_op(2, 8'd55, 8'd0, 3, 1'b0, 8'hFF, 8'd55, 1'b0, 6, 1'b1, "divzero");
`endif

    // Abort an operation in WAIT; then rr must restart from 0.
    lat = 1; hang = 1;
    bus.x_in[W +: W] = 8'd77; bus.y_in[W +: W] = 8'd5; bus.req[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) bus.req[1] = 1'b0;
    end
    chk("rst_wait busy before", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_zero("rst_wait");
    reset = 1'b0;
    run_fair(4'b1001, 2, '{0, 3, 0, 0}, "post_rst");

    mrr = 0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(1) == 1) add_req(i);
      if (pend == '0) add_req(int'($urandom_range(3)));
      bus.req = pend;
      w = -1;
      for (int o = 0; o < 4; o++)
        if (w < 0 && pend[(mrr + o) % 4]) w = (mrr + o) % 4;
      mrr = (w + 1) % 4;
      l = int'($urandom_range(20, 1));
      lat = l; hang = 0;
      eerr = (l > TO);
      eq = eerr ? 8'd0 : xs[w] / ys[w];
      er = eerr ? 8'd0 : xs[w] % ys[w];
      observe(w, eq, er, eerr, eerr ? TO + 3 : l + 3, 1'b1, $sformatf("rand%0d", it));
      pend[w] = 1'b0;
    end

    bus.req = '0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
